fanout_fork_eager: RTL and testbench

Parametrised eager-fork stage for sparse-stream fanout in the onyx PE/MEM fabric. It replaces the combinational all-consumers-ready AND with a registered fork. One producer stream is buffered in a 2-entry skid FIFO and delivered to up to NUM_OUT consumers. Each consumer may accept the head token in a different cycle; the token retires only once every active consumer has taken it. Per-channel routing is configured by enable and select bits, latched only at token boundaries.

---
 rtl/fanout_pkg.sv | 15 +
 rtl/fanout_skid_fifo.sv | 79 +++++++
 rtl/fanout_fork_eager.sv | 97 +++++++++
 tb/tb_fanout_fork_eager.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fanout_pkg.sv
// Shared constants and types for the eager fanout fork.
//   NUM_OUT_DEF / DATA_W_DEF / STALL_W_DEF : default parameter values
//   cnt_t                                  : 2-bit skid FIFO occupancy
package fanout_pkg;

  localparam int unsigned NUM_OUT_DEF = 7;
  localparam int unsigned DATA_W_DEF  = 17;
  localparam int unsigned STALL_W_DEF = 16;

  localparam int unsigned CNT_W = 2;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t FIFO_DEPTH = cnt_t'(2);

endpackage

// File: rtl/fanout_skid_fifo.sv
// Two-entry skid FIFO. Entry "head" always holds the oldest token, so the
// read data is a plain register with no read mux.
//   clk, rst_n     : clock, synchronous active-low reset
//   push_i, data_i : write request and token (ignored when full)
//   pop_i          : retire the head (ignored when empty)
//   data_o         : head token
//   head_valid_o   : FIFO holds at least one token
//   not_full_o     : registered count < 2
//   count_o        : registered occupancy
module fanout_skid_fifo
  import fanout_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              head_valid_o,
  output logic              not_full_o,
  output cnt_t              count_o
);

  cnt_t              cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              not_full_q;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push_i & not_full_q;
  assign pop_ok  = pop_i & (cnt_q != '0);

  // Next occupancy and storage update.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push_ok && !pop_ok) begin
      if (cnt_q == '0) begin
        head_d = data_i;
      end else begin
        tail_d = data_i;
      end
      cnt_d = cnt_q + cnt_t'(1);
    end else if (!push_ok && pop_ok) begin
      if (cnt_q == FIFO_DEPTH) begin
        head_d = tail_q;
      end
      cnt_d = cnt_q - cnt_t'(1);
    end else if (push_ok && pop_ok) begin
      // Only reachable with one entry: the new token replaces the head.
      head_d = data_i;
    end
  end

  // Storage and registered full flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      not_full_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      not_full_q <= (cnt_d != FIFO_DEPTH);
    end
  end

  assign data_o       = head_q;
  assign head_valid_o = (cnt_q != '0);
  assign not_full_o   = not_full_q;
  assign count_o      = cnt_q;

endmodule

// File: rtl/fanout_fork_eager.sv
// Registered eager fork: one producer stream, buffered in a skid FIFO, is
// delivered to up to NUM_OUT consumers that may each accept the head token in
// a different cycle. The token retires once every active consumer has it.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_data/valid/ready   : producer stream (in_ready registered)
//   out_data              : head token shared by all channels
//   out_valid/out_ready   : per-channel handshake
//   cfg_enable, cfg_sel   : routing config, latched only while the FIFO is empty
//   active_q              : latched active mask
//   stall_cnt             : saturating count of cycles the head was held
module fanout_fork_eager
  import fanout_pkg::*;
#(
  parameter int unsigned NUM_OUT = NUM_OUT_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned STALL_W = STALL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  input  logic [NUM_OUT-1:0] cfg_enable,
  input  logic [NUM_OUT-1:0] cfg_sel,
  output logic [NUM_OUT-1:0] active_q,
  output logic [STALL_W-1:0] stall_cnt
);

  logic               head_valid;
  logic               push;
  logic               pop;
  cnt_t               fifo_cnt;
  logic [NUM_OUT-1:0] hs;
  logic [NUM_OUT-1:0] active_d;
  logic [NUM_OUT-1:0] done_q, done_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  assign push = in_valid & in_ready;

  fanout_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .data_i       (in_data),
    .pop_i        (pop),
    .data_o       (out_data),
    .head_valid_o (head_valid),
    .not_full_o   (in_ready),
    .count_o      (fifo_cnt)
  );

  // A channel still owes a handshake until it is done; valid comes only from state.
  assign out_valid = {NUM_OUT{head_valid}} & active_q & ~done_q;
  assign hs        = out_valid & out_ready;

  // Retire when every active channel is done already or taking it now.
  // An all-zero mask therefore sinks the head immediately.
  assign pop = head_valid & (&(~active_q | done_q | out_ready));

  // Mask latch, delivery tracking and stall counter.
  always_comb begin
    active_d = active_q;
    done_d   = done_q;
    stall_d  = stall_q;
    if (fifo_cnt == '0) begin
      active_d = cfg_enable & cfg_sel;
    end
    if (pop) begin
      done_d = '0;
    end else begin
      done_d = done_q | hs;
    end
    if (head_valid && !pop && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= '0;
      done_q   <= '0;
      stall_q  <= '0;
    end else begin
      active_q <= active_d;
      done_q   <= done_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fanout_fork_eager.sv
// Bench for fanout_fork_eager: hand-derived vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fanout_fork_eager;

  localparam int unsigned N  = 7;
  localparam int unsigned DW = 17;
  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] SMAX = '1;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [N-1:0]  cfg_enable;
  logic [N-1:0]  cfg_sel;
  logic [N-1:0]  active_q;
  logic [SW-1:0] stall_cnt;

  fanout_fork_eager #(
    .NUM_OUT (N),
    .DATA_W  (DW),
    .STALL_W (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cfg_enable (cfg_enable),
    .cfg_sel    (cfg_sel),
    .active_q   (active_q),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: token queue plus per-token delivery bookkeeping.
  logic [DW-1:0] mq[$];
  logic [N-1:0]  m_active;
  logic [N-1:0]  m_done;
  logic [SW-1:0] m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = '0;
    m_done   = '0;
    m_stall  = '0;
  endtask

  // Compare outputs with the model, take one clock edge, advance the model.
  // Called and returns at a negative clock edge.
  task automatic tick();
    logic         hv;
    logic         pop;
    logic         push;
    logic [N-1:0] exp_ov;
    hv     = (mq.size() != 0);
    exp_ov = hv ? (m_active & ~m_done) : '0;
    chk("m_in_ready",  32'(in_ready),  32'(mq.size() < 2));
    chk("m_out_valid", 32'(out_valid), 32'(exp_ov));
    chk("m_active_q",  32'(active_q),  32'(m_active));
    chk("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
    if (hv) chk("m_out_data", 32'(out_data), 32'(mq[0]));
    // Every active channel must be served already or be ready now.
    pop  = hv && ((m_active & ~m_done & ~out_ready) == '0);
    push = in_valid && (mq.size() < 2);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (mq.size() == 0) m_active = cfg_enable & cfg_sel;
      if (hv && !pop && m_stall != SMAX) m_stall = m_stall + 1'b1;
      if (pop) begin
        void'(mq.pop_front());
        m_done = '0;
      end else begin
        m_done = m_done | (exp_ov & out_ready);
      end
      if (push) mq.push_back(in_data);
    end
    @(negedge clk);
  endtask

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] data;
    logic [N-1:0]  rdy;
    logic [N-1:0]  en;
    logic [N-1:0]  sel;
    logic          e_ir;
    logic [N-1:0]  e_ov;
    logic          e_chk_d;
    logic [DW-1:0] e_d;
    logic [N-1:0]  e_act;
    logic [SW-1:0] e_st;
  } vec_t;

  vec_t vecs[12];

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = '0;
    cfg_enable = 7'h7F;
    cfg_sel    = 7'h7F;

    // Expected values are the state after the row's clock edge.
    // Broadcast: four back-to-back tokens to all seven channels.
    vecs[0]  = '{1'b1, 17'h1,  7'h7F, 7'h7F, 7'h7F, 1'b1, 7'h7F, 1'b1, 17'h1,  7'h7F, 4'd0};
    vecs[1]  = '{1'b1, 17'h2,  7'h7F, 7'h7F, 7'h7F, 1'b1, 7'h7F, 1'b1, 17'h2,  7'h7F, 4'd0};
    vecs[2]  = '{1'b1, 17'h3,  7'h7F, 7'h7F, 7'h7F, 1'b1, 7'h7F, 1'b1, 17'h3,  7'h7F, 4'd0};
    vecs[3]  = '{1'b1, 17'h4,  7'h7F, 7'h7F, 7'h7F, 1'b1, 7'h7F, 1'b1, 17'h4,  7'h7F, 4'd0};
    vecs[4]  = '{1'b0, 17'h0,  7'h7F, 7'h7F, 7'h7F, 1'b1, 7'h00, 1'b0, 17'h0,  7'h7F, 4'd0};
    // Staggered accept on ch0..ch2: ready in cycles 1, 2 and 4.
    vecs[5]  = '{1'b0, 17'h0,  7'h00, 7'h7F, 7'h07, 1'b1, 7'h00, 1'b0, 17'h0,  7'h07, 4'd0};
    vecs[6]  = '{1'b1, 17'h10, 7'h00, 7'h7F, 7'h07, 1'b1, 7'h07, 1'b1, 17'h10, 7'h07, 4'd0};
    vecs[7]  = '{1'b0, 17'h0,  7'h01, 7'h7F, 7'h07, 1'b1, 7'h06, 1'b1, 17'h10, 7'h07, 4'd1};
    vecs[8]  = '{1'b0, 17'h0,  7'h02, 7'h7F, 7'h07, 1'b1, 7'h04, 1'b1, 17'h10, 7'h07, 4'd2};
    vecs[9]  = '{1'b0, 17'h0,  7'h00, 7'h7F, 7'h07, 1'b1, 7'h04, 1'b1, 17'h10, 7'h07, 4'd3};
    vecs[10] = '{1'b0, 17'h0,  7'h04, 7'h7F, 7'h07, 1'b1, 7'h00, 1'b0, 17'h0,  7'h07, 4'd3};
    vecs[11] = '{1'b0, 17'h0,  7'h00, 7'h7F, 7'h07, 1'b1, 7'h00, 1'b0, 17'h0,  7'h07, 4'd3};

    // Reset and reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_active_q",  32'(active_q),  32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      in_valid   = vecs[i].vld;
      in_data    = vecs[i].data;
      out_ready  = vecs[i].rdy;
      cfg_enable = vecs[i].en;
      cfg_sel    = vecs[i].sel;
      tick();
      chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_active_q", i),  32'(active_q),  32'(vecs[i].e_act));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_st));
      if (vecs[i].e_chk_d) chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_d));
    end

    // Backpressure: third token waits, then drain in order.
    cfg_sel   = 7'h7F;
    out_ready = '0;
    in_valid  = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 17'h21;
    tick();
    chk("bp_ready_after_1", 32'(in_ready), 32'h1);
    in_data = 17'h22;
    tick();
    chk("bp_ready_after_2", 32'(in_ready), 32'h0);
    in_data = 17'h23;
    tick();
    tick();
    chk("bp_head_held", 32'(out_data), 32'h21);
    out_ready = 7'h7F;
    tick();
    chk("bp_drain_1", 32'(out_data), 32'h22);
    tick();
    chk("bp_drain_2", 32'(out_data), 32'h23);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(out_valid), 32'h0);

    // Masked route, then sinking with an all-zero mask.
    cfg_sel = 7'h05;
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'(17'h30 + i);
      tick();
      chk("mask_out_valid", 32'(out_valid), 32'h05);
    end
    in_valid = 1'b0;
    cfg_sel  = 7'h00;
    tick();
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = DW'(17'h40 + i);
      tick();
      chk("sink_out_valid", 32'(out_valid), 32'h00);
      chk("sink_in_ready",  32'(in_ready),  32'h1);
    end
    in_valid = 1'b0;
    tick();

    // Config change while a token is partially delivered.
    cfg_sel   = 7'h07;
    out_ready = '0;
    tick();
    in_valid = 1'b1;
    in_data  = 17'h50;
    tick();
    in_valid  = 1'b0;
    out_ready = 7'h01;
    tick();
    cfg_sel   = 7'h70;
    out_ready = '0;
    tick();
    tick();
    chk("cfg_hold_active", 32'(active_q), 32'h07);
    chk("cfg_hold_valid",  32'(out_valid), 32'h06);
    out_ready = 7'h06;
    tick();
    in_valid  = 1'b1;
    in_data   = 17'h51;
    out_ready = '0;
    tick();
    chk("cfg_new_active", 32'(active_q),  32'h70);
    chk("cfg_new_valid",  32'(out_valid), 32'h70);
    in_valid  = 1'b0;
    out_ready = 7'h7F;
    tick();

    // Reset with two tokens buffered and ch0/ch1 already served.
    cfg_sel   = 7'h07;
    out_ready = '0;
    tick();
    in_valid = 1'b1;
    in_data  = 17'h61;
    tick();
    in_data = 17'h62;
    tick();
    in_valid  = 1'b0;
    out_ready = 7'h03;
    tick();
    chk("rstmid_before", 32'(out_valid), 32'h04);
    out_ready = '0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstmid_in_ready",  32'(in_ready),  32'h1);
    chk("rstmid_out_valid", 32'(out_valid), 32'h0);
    chk("rstmid_active_q",  32'(active_q),  32'h0);
    chk("rstmid_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rstmid_out_data",  32'(out_data),  32'h0);
    in_valid = 1'b1;
    in_data  = 17'h63;
    tick();
    chk("rstmid_next_valid", 32'(out_valid), 32'h07);
    chk("rstmid_next_data",  32'(out_data),  32'h63);
    in_valid  = 1'b0;
    out_ready = 7'h7F;
    tick();

    // Stall counter saturation.
    cfg_sel   = 7'h01;
    out_ready = '0;
    tick();
    in_valid = 1'b1;
    in_data  = 17'h70;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("stall_saturated", 32'(stall_cnt), 32'(SMAX));
    out_ready = 7'h01;
    tick();
    chk("stall_after_pop", 32'(stall_cnt), 32'(SMAX));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 2) == 0) ? N'($urandom) : '1;
      if ($urandom_range(0, 15) == 0) begin
        cfg_enable = N'($urandom);
        cfg_sel    = N'($urandom);
      end
      tick();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
